// File: rtl/prbs16_pkg.sv
// Shared PRBS16 definitions: one polynomial for both the lfsr_16 generator and the checker.
package prbs16_pkg;

    localparam int LFSR_W = 16;

    // Feedback taps at bits 15, 13, 12, 10 (x^16+x^14+x^13+x^11+1)
    localparam logic [LFSR_W-1:0] PRBS16_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } prbs_state_e;

    // Fibonacci form, left shift: new LSB is the XOR of the tapped bits
    function automatic logic [LFSR_W-1:0] lfsr16_next(input logic [LFSR_W-1:0] w);
        return {w[LFSR_W-2:0], ^(w & PRBS16_TAPS)};
    endfunction

endpackage

// File: rtl/prbs16_checker.sv
// Self-synchronising PRBS16 checker: seeds from the incoming stream, locks after
// LOCK_CNT correct predictions, then flywheels and counts deviating words.
module prbs16_checker
    import prbs16_pkg::*;
#(
    parameter int ERR_W    = 16,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [15:0]       lfsr,
    input  logic              clear_cnt,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count
);

    localparam logic [4:0] LOCK_CNT_V = 5'(LOCK_CNT);
    localparam logic [4:0] LOSS_CNT_V = 5'(LOSS_CNT);

    prbs_state_e       r_state;
    logic [LFSR_W-1:0] r_ref;
    logic [3:0]        r_run;
    logic              r_locked;
    logic              r_err_pulse;
    logic [ERR_W-1:0]  r_err_count;

    logic [LFSR_W-1:0] w_pred;
    logic              w_nonzero;
    logic              w_match;
    logic [4:0]        w_run_inc;

    assign w_pred    = lfsr16_next(r_ref);
    assign w_nonzero = (lfsr != '0);
    assign w_match   = enable && (lfsr == w_pred) && w_nonzero;
    assign w_run_inc = {1'b0, r_run} + 5'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SEARCH;
            r_ref       <= '0;
            r_run       <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            if (enable) begin
                case (r_state)
                    SEARCH: begin
                        if (w_nonzero) begin
                            r_ref   <= lfsr;
                            r_run   <= '0;
                            r_state <= SYNC;
                        end
                    end
                    SYNC: begin
                        // Any accepted word becomes the new seed, matched or not
                        r_ref <= lfsr;
                        if (w_match) begin
                            if (w_run_inc == LOCK_CNT_V) begin
                                r_run    <= '0;
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end else begin
                                r_run <= w_run_inc[3:0];
                            end
                        end else begin
                            r_run <= '0;
                            if (!w_nonzero) begin
                                r_state <= SEARCH;
                            end
                        end
                    end
                    LOCKED: begin
                        // Flywheel: prediction advances independently of the input
                        r_ref <= w_pred;
                        if (w_match) begin
                            r_run <= '0;
                        end else begin
                            r_err_pulse <= 1'b1;
                            if (r_err_count != '1) begin
                                r_err_count <= r_err_count + 1'b1;
                            end
                            if (w_run_inc == LOSS_CNT_V) begin
                                r_run    <= '0;
                                r_state  <= SEARCH;
                                r_locked <= 1'b0;
                            end else begin
                                r_run <= w_run_inc[3:0];
                            end
                        end
                    end
                    default: begin
                        r_state  <= SEARCH;
                        r_run    <= '0;
                        r_locked <= 1'b0;
                    end
                endcase
            end
            if (clear_cnt) begin
                r_err_count <= '0;
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_prbs16_checker.sv
// Scoreboard bench for prbs16_checker: per-cycle expectations are queued as each
// word is driven and compared one cycle later; a second instance has ERR_W=2.
module tb_prbs16_checker;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] lfsr;
    logic        clear_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        locked2;
    logic        err_pulse2;
    logic [1:0]  err_count2;

    typedef struct {
        logic l;
        logic p;
        int   c;
    } exp_t;

    exp_t        sb_q[$];
    int          total;
    int          bad;
    int          txn;
    logic [15:0] gen;
    int          e_cnt;

    prbs16_checker #(.ERR_W(16), .LOCK_CNT(4), .LOSS_CNT(4)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .lfsr      (lfsr),
        .clear_cnt (clear_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    prbs16_checker #(.ERR_W(2), .LOCK_CNT(4), .LOSS_CNT(4)) u_dut_sat (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .lfsr      (lfsr),
        .clear_cnt (clear_cnt),
        .locked    (locked2),
        .err_pulse (err_pulse2),
        .err_count (err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference next-state written directly from the polynomial
    function automatic logic [15:0] nxt(input logic [15:0] w);
        return {w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]};
    endfunction

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s txn=%0d got=%0h want=%0h", tag, txn, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic [15:0] w,
                        input logic clr, input logic exp_l, input logic exp_p, input int exp_c);
        exp_t e;
        int   c2;
        reset     = rst;
        enable    = en;
        lfsr      = w;
        clear_cnt = clr;
        sb_q.push_back('{l: exp_l, p: exp_p, c: exp_c});
        @(posedge clk);
        #1;
        e  = sb_q.pop_front();
        c2 = (e.c > 3) ? 3 : e.c;
        txn++;
        $display("txn %0d rst=%0b en=%0b w=%04h clr=%0b -> locked=%0b pulse=%0b cnt=%0d sat_cnt=%0d",
                 txn, rst, en, w, clr, locked, err_pulse, err_count, err_count2);
        chk("locked", longint'(locked), longint'(e.l));
        chk("err_pulse", longint'(err_pulse), longint'(e.p));
        chk("err_count", longint'(err_count), longint'(e.c));
        chk("locked_sat", longint'(locked2), longint'(e.l));
        chk("err_pulse_sat", longint'(err_pulse2), longint'(e.p));
        chk("err_count_sat", longint'(err_count2), longint'(c2));
    endtask

    // Correct word from the generator, then advance it
    task automatic good(input logic exp_l);
        step(1'b0, 1'b1, gen, 1'b0, exp_l, 1'b0, e_cnt);
        gen = nxt(gen);
    endtask

    // Corrupted word in place of the generator output; generator still advances
    task automatic corrupt(input logic [15:0] mask, input logic clr, input logic exp_l);
        e_cnt = clr ? 0 : e_cnt + 1;
        step(1'b0, 1'b1, gen ^ mask, clr, exp_l, 1'b1, e_cnt);
        gen = nxt(gen);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        txn       = 0;
        e_cnt     = 0;
        gen       = 16'hACE1;
        reset     = 1'b1;
        enable    = 1'b0;
        lfsr      = '0;
        clear_cnt = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 0);

        // Acquire: locked after the 5th word, then a long clean run
        for (int i = 0; i < 4; i++) good(1'b0);
        good(1'b1);
        for (int i = 0; i < 995; i++) good(1'b1);

        // Single bit error while locked; flywheel keeps the next word matching
        corrupt(16'h0001, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) good(1'b1);

        // Three misses, a match resets the run, then four misses drop lock
        for (int i = 0; i < 3; i++) corrupt(16'h5A5A, 1'b0, 1'b1);
        good(1'b1);
        for (int i = 0; i < 3; i++) corrupt(16'h00FF, 1'b0, 1'b1);
        corrupt(16'h00FF, 1'b0, 1'b0);

        // Relock on the continuing good stream after 5 words
        for (int i = 0; i < 4; i++) good(1'b0);
        good(1'b1);
        for (int i = 0; i < 3; i++) good(1'b1);

        // Clear coincident with an error: count 0, pulse still fires
        corrupt(16'h8000, 1'b1, 1'b1);
        good(1'b1);
        corrupt(16'h0010, 1'b0, 1'b1);
        good(1'b1);

        // Reset mid-lock
        e_cnt = 0;
        step(1'b1, 1'b1, gen, 1'b0, 1'b0, 1'b0, 0);

        // All-zero stream never leaves SEARCH
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 0);

        // Enable toggling with junk on idle cycles; only enabled words advance
        gen = 16'hACE1;
        for (int i = 0; i < 12; i++) begin
            good(i >= 4);
            step(1'b0, 1'b0, 16'(($urandom() & 16'hFFFF) | 16'h0001), 1'b0, i >= 4, 1'b0, 0);
        end

        // Gap-transparent error while locked with enable toggling
        corrupt(16'h0100, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, e_cnt);
        good(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
